silent_lpf_sched: RTL and testbench

//  Sequences the shared silent-LPF step datapath across all TRANS_NUM transducers.
//  - A programmable divider produces step ticks. Each tick runs one sweep, issuing

---
 rtl/silent_lpf_sched.sv | 109 ++++++++++
 tb/tb_silent_lpf_sched.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/silent_lpf_sched.sv
// silent_lpf_sched: divides the LPF clock into step ticks and walks every transducer
// index through the shared LPF step datapath, deferring target loads to sweep boundaries.
module silent_lpf_sched #(
    parameter int TRANS_NUM = 249,
    parameter int IDX_W     = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [15:0]      step_div_i,
    input  logic             silent_en_i,
    input  logic             update_i,
    input  logic             overrun_clr_i,
    input  logic             lpf_ready_i,
    output logic             lpf_valid_o,
    output logic [IDX_W-1:0] lpf_idx_o,
    output logic             lpf_mode_o,
    output logic             tgt_we_o,
    output logic             sweep_done_o,
    output logic             busy_o,
    output logic             overrun_o
);
    typedef enum logic [1:0] {IDLE, LOAD, SWEEP, DONE} state_t;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(TRANS_NUM - 1);
    state_t           state_q;
    logic [15:0]      div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0] idx_q;
    logic             tick, go_load, go_sweep;
    logic             pend_upd_q, pend_upd_d, pend_tick_q, pend_tick_d, overrun_q, overrun_d;
    logic             valid_q, mode_q, tgt_we_q, done_q, busy_q;
    always_comb begin
        tick      = div_cnt_q >= step_div_i;
        div_cnt_d = tick ? '0 : div_cnt_q + 16'd1;
        go_load   = state_q == IDLE && (update_i || pend_upd_q);
        go_sweep  = state_q == IDLE && !go_load && (tick || pend_tick_q);
        // A tick that cannot start a sweep right now (busy, or losing to a load) is held.
        pend_upd_d  = !go_load && (pend_upd_q || (update_i && state_q != IDLE));
        pend_tick_d = !go_sweep && (pend_tick_q || tick);
        // Setting wins over a coincident clear so a lost tick is never hidden.
        overrun_d = (tick && pend_tick_q && state_q != IDLE) || (overrun_q && !overrun_clr_i);
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_cnt_q   <= '0;
            pend_upd_q  <= 1'b0;
            pend_tick_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            pend_upd_q  <= pend_upd_d;
            pend_tick_q <= pend_tick_d;
            overrun_q   <= overrun_d;
        end
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            mode_q   <= 1'b0;
            tgt_we_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (go_load) begin
                        state_q  <= LOAD;
                        tgt_we_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end else if (go_sweep) begin
                        state_q <= SWEEP;
                        idx_q   <= '0;
                        valid_q <= 1'b1;
                        mode_q  <= ~silent_en_i;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    state_q  <= IDLE;
                    tgt_we_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
                SWEEP: begin
                    if (lpf_ready_i) begin
                        if (idx_q == LAST) begin
                            state_q <= DONE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
    assign lpf_valid_o  = valid_q;
    assign lpf_idx_o    = idx_q;
    assign lpf_mode_o   = mode_q;
    assign tgt_we_o     = tgt_we_q;
    assign sweep_done_o = done_q;
    assign busy_o       = busy_q;
    assign overrun_o    = overrun_q;
endmodule

// File: tb/tb_silent_lpf_sched.sv
// tb_silent_lpf_sched: directed checks of tick timing, sweep order, stalls, deferred
// target loads, overrun handling, mode latching and asynchronous reset.
module tb_silent_lpf_sched;
    logic        clk, rst_n;
    logic [15:0] step_div;
    logic        silent_en, update, overrun_clr, ready;
    logic        valid, mode, tgt_we, done, busy, overrun;
    logic [7:0]  idx;
    int          checks = 0, failures = 0, cyc = 0, t = 0;

    silent_lpf_sched #(.TRANS_NUM(249), .IDX_W(8)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .step_div_i(step_div), .silent_en_i(silent_en),
        .update_i(update), .overrun_clr_i(overrun_clr), .lpf_ready_i(ready),
        .lpf_valid_o(valid), .lpf_idx_o(idx), .lpf_mode_o(mode), .tgt_we_o(tgt_we),
        .sweep_done_o(done), .busy_o(busy), .overrun_o(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at t=%0d", tag, got, exp, t);
        end
    endtask

    task automatic adv(input int target);
        while (t < target) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        t = 0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!valid && n < 3000) begin
            @(negedge clk);
            n++;
            t++;
        end
        if (!valid) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        int g = 0;
        while (!done && g < 3000) begin
            @(negedge clk);
            g++;
            t++;
        end
        chk("done_seen", 32'(done), 32'd1);
    endtask

    initial begin
        int n, t0, ex, ph, g, cnt;
        rst_n = 1'b0; step_div = 16'd300; silent_en = 1'b1;
        update = 1'b0; overrun_clr = 1'b0; ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_outs", 32'({valid, idx, mode, tgt_we, done, busy, overrun}), 32'd0);
        rst_n = 1'b1;
        t = 0;
        // ten back-to-back sweeps at STEP_DIV=300
        wait_valid(n);
        chk("first_tick", 32'(n), 32'd301);
        for (int s = 0; s < 10; s++) begin
            if (s > 0) begin
                wait_valid(n);
                chk("tick_period", 32'(cyc - t0), 32'd301);
            end
            t0 = cyc;
            for (int k = 0; k < 249; k++) begin
                chk("sweep_valid", 32'(valid), 32'd1);
                chk("sweep_idx", 32'(idx), 32'(k));
                @(negedge clk);
            end
            chk("done_pulse", 32'(done), 32'd1);
            chk("done_valid", 32'(valid), 32'd0);
            @(negedge clk);
            chk("done_single", 32'(done), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end
        chk("no_overrun", 32'(overrun), 32'd0);
        // asynchronous reset in the middle of a sweep
        wait_valid(n);
        repeat (10) @(negedge clk);
        chk("pre_rst_valid", 32'(valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async", 32'({valid, idx, mode, tgt_we, done, busy, overrun}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        chk("rst_busy", 32'(busy), 32'd0);
        wait_valid(n);
        chk("rst_restart", 32'(n), 32'd301);
        chk("rst_idx0", 32'(idx), 32'd0);
        wait_done();
        @(negedge clk);
        // READY high one cycle in three
        ready = 1'b0;
        step_div = 16'd1000;
        wait_valid(n);
        ex = 0; ph = 0; g = 0;
        while (ex < 249 && g < 3000) begin
            chk("stall_valid", 32'(valid), 32'd1);
            chk("stall_idx", 32'(idx), 32'(ex));
            ready = (ph % 3 == 2);
            @(negedge clk);
            if (ready) ex++;
            ph++; g++;
        end
        chk("stall_all_taken", 32'(ex), 32'd249);
        chk("stall_done", 32'(done), 32'd1);
        chk("stall_done_valid", 32'(valid), 32'd0);
        ready = 1'b1;
        @(negedge clk);
        // UPDATE during a sweep is deferred and collapsed
        wait_valid(n);
        repeat (100) @(negedge clk);
        chk("upd_at_idx", 32'(idx), 32'd100);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        repeat (49) @(negedge clk);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        g = 0;
        while (!done && g < 500) begin
            chk("no_tgt_mid", 32'(tgt_we), 32'd0);
            @(negedge clk);
            g++;
        end
        chk("upd_done", 32'(done), 32'd1);
        chk("tgt_at_done", 32'(tgt_we), 32'd0);
        @(negedge clk);
        chk("tgt_idle", 32'(tgt_we), 32'd0);
        @(negedge clk);
        chk("tgt_pulse", 32'(tgt_we), 32'd1);
        chk("tgt_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("tgt_single", 32'(tgt_we), 32'd0);
        cnt = 0; g = 0;
        while (!valid && g < 3000) begin
            if (tgt_we) cnt++;
            @(negedge clk);
            g++;
        end
        chk("tgt_extra", 32'(cnt), 32'd0);
        chk("post_upd_idx0", 32'(idx), 32'd0);
        wait_done();
        @(negedge clk);
        // UPDATE and tick in the same IDLE cycle
        step_div = 16'hffff;
        @(negedge clk);
        step_div = 16'd0;
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        step_div = 16'd1000;
        chk("coinc_tgt", 32'(tgt_we), 32'd1);
        chk("coinc_novalid", 32'(valid), 32'd0);
        @(negedge clk);
        chk("coinc_tgt_off", 32'(tgt_we), 32'd0);
        chk("coinc_idle", 32'(valid), 32'd0);
        @(negedge clk);
        chk("coinc_sweep", 32'(valid), 32'd1);
        chk("coinc_idx0", 32'(idx), 32'd0);
        // STEP_DIV=100: pended tick then overrun
        step_div = 16'd100;
        do_reset();
        adv(100); chk("ov_no_tick", 32'(valid), 32'd0);
        adv(101); chk("ov_sweep1", 32'(valid), 32'd1);
        adv(302); chk("ov_before", 32'(overrun), 32'd0);
        adv(303); chk("ov_set", 32'(overrun), 32'd1);
        adv(350); chk("ov_done1", 32'(done), 32'd1);
        adv(351); chk("ov_idle", 32'(busy), 32'd0);
        adv(352); chk("ov_pended", 32'(valid), 32'd1);
        chk("ov_pended_idx", 32'(idx), 32'd0);
        adv(504); overrun_clr = 1'b1;
        adv(505); overrun_clr = 1'b0;
        chk("ov_clr_coinc", 32'(overrun), 32'd1);
        adv(506); overrun_clr = 1'b1;
        adv(507); overrun_clr = 1'b0;
        chk("ov_clr", 32'(overrun), 32'd0);
        // SILENT_EN latched per sweep
        step_div = 16'd300;
        silent_en = 1'b0;
        do_reset();
        wait_valid(n);
        chk("mode_bypass", 32'(mode), 32'd1);
        repeat (50) @(negedge clk);
        chk("mode_idx50", 32'(idx), 32'd50);
        silent_en = 1'b1;
        @(negedge clk);
        chk("mode_hold", 32'(mode), 32'd1);
        wait_done();
        chk("mode_hold_done", 32'(mode), 32'd1);
        @(negedge clk);
        wait_valid(n);
        chk("mode_step", 32'(mode), 32'd0);
        repeat (50) @(negedge clk);
        silent_en = 1'b0;
        @(negedge clk);
        chk("mode_hold2", 32'(mode), 32'd0);
        wait_done();
        chk("mode_hold2_done", 32'(mode), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
